hpdcache_l15_req_arb_rt: RTL and testbench

//  Upstream companion of the L1.5 response demux.
//  - Round-robin arbitration of N requester ports onto one memory request channel.
//  - For every accepted request, records the requesting port in a routing table indexed by transaction ID.
//  - Looks up the returning response ID to produce the port select that drives the response demux.

---
 rtl/hpdcache_l15_req_arb_rt.sv | 145 ++++++++++++++
 tb/tb_hpdcache_l15_req_arb_rt.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_l15_req_arb_rt.sv
// Round-robin request arbiter with an ID-indexed routing table.
// Accepted requests record their source port under their transaction ID so
// the returning response can be steered back by the downstream demux.
module hpdcache_l15_req_arb_rt #(
  parameter int unsigned N        = 4,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned PORTID_W = 2,
  parameter int unsigned REQ_W    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N-1:0]          req_valid_i,
  output logic [N-1:0]          req_ready_o,
  input  logic [N*REQ_W-1:0]    req_i,
  input  logic [N*ID_W-1:0]     req_id_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [REQ_W-1:0]      mem_req_o,
  output logic [ID_W-1:0]       mem_req_id_o,
  input  logic                  mem_resp_valid_i,
  input  logic                  mem_resp_ready_i,
  input  logic [ID_W-1:0]       mem_resp_id_i,
  input  logic                  mem_resp_last_i,
  output logic [PORTID_W-1:0]   mem_sel_o,
  output logic                  mem_resp_err_o,
  output logic [ID_W:0]         outstanding_o
);

  localparam int unsigned DEPTH = 2**ID_W;

  logic [DEPTH-1:0]    rt_valid_q, rt_valid_d;
  logic [PORTID_W-1:0] rt_port_q [DEPTH];
  logic [PORTID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic                lock_q, lock_d;
  logic [PORTID_W-1:0] lock_port_q, lock_port_d;
  logic [ID_W:0]       outstanding_q, outstanding_d;

  logic [N-1:0]        eligible;
  logic                gnt_valid;
  logic [PORTID_W-1:0] gnt;
  logic                req_hs;
  logic                resp_free;

  // A port competes only if its ID is not already in flight (registered table, no bypass).
  always_comb begin
    eligible = '0;
    for (int unsigned p = 0; p < N; p++) begin
      eligible[p] = req_valid_i[p] & ~rt_valid_q[req_id_i[p*ID_W +: ID_W]];
    end
  end

  // Grant: hold the locked port, else first eligible at/after rr_ptr.
  // The rotation is split into two constant-index passes (ports >= rr_ptr, then ports < rr_ptr).
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    if (lock_q) begin
      gnt_valid = 1'b1;
      gnt       = lock_port_q;
    end else begin
      for (int unsigned p = 0; p < N; p++) begin
        if (!gnt_valid && eligible[p] && (p >= 32'(rr_ptr_q))) begin
          gnt_valid = 1'b1;
          gnt       = PORTID_W'(p);
        end
      end
      for (int unsigned p = 0; p < N; p++) begin
        if (!gnt_valid && eligible[p] && (p < 32'(rr_ptr_q))) begin
          gnt_valid = 1'b1;
          gnt       = PORTID_W'(p);
        end
      end
    end
    if (rst_i) gnt_valid = 1'b0;
  end

  // Request-side outputs muxed from the granted port.
  always_comb begin
    req_ready_o  = '0;
    mem_req_o    = '0;
    mem_req_id_o = '0;
    for (int unsigned p = 0; p < N; p++) begin
      if (gnt == PORTID_W'(p)) begin
        mem_req_o    = req_i[p*REQ_W +: REQ_W];
        mem_req_id_o = req_id_i[p*ID_W +: ID_W];
        req_ready_o[p] = gnt_valid & mem_req_ready_i;
      end
    end
  end

  assign mem_req_valid_o = gnt_valid;
  assign req_hs          = gnt_valid & mem_req_ready_i;

  // Zero-latency response lookup.
  assign mem_sel_o      = rt_valid_q[mem_resp_id_i] ? rt_port_q[mem_resp_id_i] : '0;
  assign mem_resp_err_o = mem_resp_valid_i & ~rt_valid_q[mem_resp_id_i];
  assign resp_free      = mem_resp_valid_i & mem_resp_ready_i & mem_resp_last_i & ~mem_resp_err_o;
  assign outstanding_o  = outstanding_q;

  // Next-state: table alloc/free, round-robin pointer, lock and occupancy count.
  always_comb begin
    rt_valid_d    = rt_valid_q;
    rr_ptr_d      = rr_ptr_q;
    lock_d        = lock_q;
    lock_port_d   = lock_port_q;
    outstanding_d = outstanding_q;
    if (resp_free) rt_valid_d[mem_resp_id_i] = 1'b0;
    if (req_hs) begin
      rt_valid_d[mem_req_id_o] = 1'b1;
      rr_ptr_d = (gnt == PORTID_W'(N-1)) ? '0 : gnt + PORTID_W'(1);
      lock_d   = 1'b0;
    end else if (gnt_valid) begin
      lock_d      = 1'b1;
      lock_port_d = gnt;
    end
    case ({req_hs, resp_free})
      2'b10:   outstanding_d = outstanding_q + (ID_W+1)'(1);
      2'b01:   outstanding_d = outstanding_q - (ID_W+1)'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rt_valid_q    <= '0;
      rr_ptr_q      <= '0;
      lock_q        <= 1'b0;
      lock_port_q   <= '0;
      outstanding_q <= '0;
    end else begin
      rt_valid_q    <= rt_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_q        <= lock_d;
      lock_port_q   <= lock_port_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Port field of the routing table; only meaningful where rt_valid_q is set.
  always_ff @(posedge clk_i) begin
    if (req_hs) rt_port_q[mem_req_id_o] <= gnt;
  end

endmodule

// File: tb/tb_hpdcache_l15_req_arb_rt.sv
// Testbench for hpdcache_l15_req_arb_rt: vector table, directed corner
// sequences, then random traffic against a behavioural table model.
module tb_hpdcache_l15_req_arb_rt;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready;
  logic [255:0] req_pl;
  logic [15:0]  req_id;
  logic         mem_req_valid, mem_ready;
  logic [63:0]  mem_req;
  logic [3:0]   mem_req_id;
  logic         resp_valid, resp_ready, resp_last;
  logic [3:0]   resp_id;
  logic [1:0]   sel;
  logic         err;
  logic [4:0]   outst;

  int checks = 0;
  int failures = 0;

  hpdcache_l15_req_arb_rt #(.N(4), .ID_W(4), .PORTID_W(2), .REQ_W(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req_pl), .req_id_i(req_id),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_req_id_o(mem_req_id),
    .mem_resp_valid_i(resp_valid), .mem_resp_ready_i(resp_ready),
    .mem_resp_id_i(resp_id), .mem_resp_last_i(resp_last),
    .mem_sel_o(sel), .mem_resp_err_o(err), .outstanding_o(outst)
  );

  always #5 clk = ~clk;

  // Behavioural model: which IDs are in flight and from which port.
  bit m_valid[16];
  int m_port[16];
  int m_rr;
  bit m_lock;
  int m_lock_port;
  bit e_gv;
  int e_g;
  bit e_err;
  int e_sel;
  int last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  function automatic void model_comb();
    int p;
    e_gv = 1'b0;
    e_g  = 0;
    if (!rst) begin
      if (m_lock) begin
        e_gv = 1'b1;
        e_g  = m_lock_port;
      end else begin
        for (int k = 0; k < 4; k++) begin
          p = (m_rr + k) % 4;
          if (!e_gv && req_valid[p] && !m_valid[req_id[p*4 +: 4]]) begin
            e_gv = 1'b1;
            e_g  = p;
          end
        end
      end
    end
    e_err = resp_valid && !m_valid[resp_id];
    e_sel = m_valid[resp_id] ? m_port[resp_id] : 0;
  endfunction

  function automatic void model_seq();
    last_acc = -1;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_rr = 0;
      m_lock = 1'b0;
    end else begin
      if (resp_valid && resp_ready && resp_last && !e_err) m_valid[resp_id] = 1'b0;
      if (e_gv && mem_ready) begin
        m_valid[req_id[e_g*4 +: 4]] = 1'b1;
        m_port[req_id[e_g*4 +: 4]]  = e_g;
        m_rr     = (e_g + 1) % 4;
        m_lock   = 1'b0;
        last_acc = e_g;
      end else if (e_gv) begin
        m_lock      = 1'b1;
        m_lock_port = e_g;
      end
    end
  endfunction

  // Mid-cycle: compare combinational outputs against the model.
  task automatic settle();
    logic [3:0] xr;
    #3;
    model_comb();
    xr = '0;
    if (e_gv) xr[e_g] = mem_ready;
    chk("mem_req_valid", mem_req_valid, e_gv);
    chk("req_ready", req_ready, xr);
    if (e_gv) begin
      chk("mem_req_id", mem_req_id, req_id[e_g*4 +: 4]);
      chk("mem_req", mem_req, req_pl[e_g*64 +: 64]);
    end
    chk("mem_sel", sel, e_sel);
    chk("mem_resp_err", err, e_err);
  endtask

  // Clock edge: advance the model, then check the registered count.
  task automatic tick();
    @(posedge clk);
    model_seq();
    #1;
    chk("outstanding", outst, model_count());
  endtask

  task automatic idle_inputs();
    req_valid = '0; mem_ready = 1'b0;
    resp_valid = 1'b0; resp_ready = 1'b1; resp_last = 1'b0; resp_id = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] vld;
    logic [15:0] ids;
    bit         mrdy;
    bit         rv;
    bit         rl;
    logic [3:0] rid;
    bit         x_mv;
    logic [3:0] x_rdy;
    logic [3:0] x_mid;
    logic [1:0] x_sel;
    bit         x_err;
    logic [4:0] x_out;
  } vec_t;

  vec_t tbl[9];

  initial begin
    rst = 1'b1;
    req_id = '0;
    for (int p = 0; p < 4; p++) req_pl[p*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(p);
    idle_inputs();
    m_rr = 0; m_lock = 1'b0; m_lock_port = 0; last_acc = -1;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_port[i] = 0; end
    @(posedge clk);
    #1;

    // rst vld ids mrdy rv rl rid | mv rdy mid sel err out
    tbl[0] = '{1'b1, 4'b0000, 16'h3210, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0, 5'd0};
    tbl[1] = '{1'b0, 4'b1111, 16'h3210, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'b0001, 4'h0, 2'd0, 1'b0, 5'd1};
    tbl[2] = '{1'b0, 4'b1111, 16'h3210, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'b0010, 4'h1, 2'd0, 1'b0, 5'd2};
    tbl[3] = '{1'b0, 4'b1111, 16'h3210, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'b0100, 4'h2, 2'd0, 1'b0, 5'd3};
    tbl[4] = '{1'b0, 4'b1111, 16'h3210, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'b1000, 4'h3, 2'd0, 1'b0, 5'd4};
    tbl[5] = '{1'b0, 4'b1111, 16'h3210, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0, 5'd4};
    tbl[6] = '{1'b0, 4'b0000, 16'h3210, 1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 4'b0000, 4'h0, 2'd2, 1'b0, 5'd3};
    tbl[7] = '{1'b0, 4'b0001, 16'h3210, 1'b1, 1'b1, 1'b1, 4'h9, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b1, 5'd3};
    tbl[8] = '{1'b0, 4'b0100, 16'h3210, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'b0100, 4'h2, 2'd0, 1'b0, 5'd4};

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; req_valid = tbl[i].vld; req_id = tbl[i].ids; mem_ready = tbl[i].mrdy;
      resp_valid = tbl[i].rv; resp_ready = 1'b1; resp_last = tbl[i].rl; resp_id = tbl[i].rid;
      settle();
      chk($sformatf("tbl%0d_valid", i), mem_req_valid, tbl[i].x_mv);
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].x_rdy);
      if (tbl[i].x_mv) chk($sformatf("tbl%0d_id", i), mem_req_id, tbl[i].x_mid);
      chk($sformatf("tbl%0d_sel", i), sel, tbl[i].x_sel);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].x_err);
      tick();
      chk($sformatf("tbl%0d_out", i), outst, tbl[i].x_out);
    end

    // Backpressure: port 2 locked while port 0 joins; port 0 next after accept.
    do_reset();
    req_valid = 4'b0100; req_id[8 +: 4] = 4'hA; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bp_valid", mem_req_valid, 1'b1);
      chk("bp_ready", req_ready, 4'b0000);
      chk("bp_id", mem_req_id, 4'hA);
      chk("bp_pl", mem_req, req_pl[128 +: 64]);
      tick();
      if (c == 0) begin req_valid[0] = 1'b1; req_id[0 +: 4] = 4'hB; end
    end
    mem_ready = 1'b1;
    settle();
    chk("bp_accept", req_ready, 4'b0100);
    chk("bp_accept_id", mem_req_id, 4'hA);
    tick();
    req_valid = 4'b0001;
    settle();
    chk("bp_next", req_ready, 4'b0001);
    chk("bp_next_id", mem_req_id, 4'hB);
    tick();

    // ID busy: port 3 blocked on ID 5 until the last beat is accepted.
    do_reset();
    mem_ready = 1'b1;
    req_valid = 4'b0010; req_id[4 +: 4] = 4'h5;
    settle(); chk("busy_p1", req_ready, 4'b0010); tick();
    req_valid = 4'b1000; req_id[12 +: 4] = 4'h5;
    settle(); chk("busy_block", mem_req_valid, 1'b0); tick();
    resp_valid = 1'b1; resp_last = 1'b1; resp_id = 4'h5;
    settle();
    chk("busy_nobypass", mem_req_valid, 1'b0);
    chk("busy_sel", sel, 2'd1);
    tick();
    chk("busy_freed", outst, 5'd0);
    resp_valid = 1'b0;
    settle(); chk("busy_grant", req_ready, 4'b1000); tick();
    chk("busy_out", outst, 5'd1);

    // Routing and error: 2-beat response for ID 7 from port 3, stray ID 9.
    do_reset();
    mem_ready = 1'b1;
    req_valid = 4'b1000; req_id[12 +: 4] = 4'h7;
    settle(); chk("rt_grant", req_ready, 4'b1000); tick();
    req_valid = '0;
    resp_valid = 1'b1; resp_id = 4'h7; resp_last = 1'b0;
    settle(); chk("rt_beat0_sel", sel, 2'd3); tick();
    chk("rt_beat0_out", outst, 5'd1);
    resp_id = 4'h9; resp_last = 1'b1;
    settle(); chk("err_flag", err, 1'b1); chk("err_sel", sel, 2'd0); tick();
    chk("err_out", outst, 5'd1);
    resp_id = 4'h7;
    settle(); chk("rt_beat1_sel", sel, 2'd3); chk("rt_beat1_err", err, 1'b0); tick();
    chk("rt_free_out", outst, 5'd0);
    resp_valid = 1'b0;

    // Reset mid-operation with three IDs outstanding.
    do_reset();
    mem_ready = 1'b1;
    req_valid = 4'b0111; req_id = 16'h0321;
    for (int c = 0; c < 3; c++) begin settle(); tick(); end
    chk("rm_out3", outst, 5'd3);
    rst = 1'b1;
    settle();
    chk("rm_rst_valid", mem_req_valid, 1'b0);
    chk("rm_rst_ready", req_ready, 4'b0000);
    tick();
    chk("rm_out0", outst, 5'd0);
    rst = 1'b0;
    resp_valid = 1'b1; resp_last = 1'b1; resp_id = 4'h2;
    settle();
    chk("rm_rr0", req_ready, 4'b0001);
    chk("rm_old_err", err, 1'b1);
    tick();

    // Random traffic; requesters hold valid until accepted.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 4; p++) begin
        if (!req_valid[p] || last_acc == p) begin
          req_valid[p] = 1'($urandom_range(0, 1));
          req_id[p*4 +: 4] = 4'($urandom_range(0, 15));
          req_pl[p*64 +: 64] = {$urandom, $urandom};
        end
      end
      rst        = ($urandom_range(0, 99) == 0);
      mem_ready  = ($urandom_range(0, 99) < 60);
      resp_valid = ($urandom_range(0, 99) < 50);
      resp_ready = ($urandom_range(0, 99) < 75);
      resp_last  = 1'($urandom_range(0, 1));
      resp_id    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 80) begin
        for (int k = 0; k < 16; k++) begin
          if (m_valid[(int'(resp_id) + k) % 16]) begin
            resp_id = 4'((int'(resp_id) + k) % 16);
            break;
          end
        end
      end
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
